pq_shift_cell: RTL

Parametrised storage cell for the linear shift-register priority queue; DEPTH instances chained left (higher priority) to right (lower priority) form the queue array. Each cell holds one {priority, id} entry plus its valid flag. On each broadcast command (push, pop, push+pop, drop-by-id) the cell reloads itself from the new entry, its left neighbour or its right neighbour, so the array stays sorted. Cell 0 is the queue head.

---
 rtl/pq_shift_cell.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pq_shift_cell.sv
// pq_shift_cell
//   One storage cell of a linear shift-register priority queue. DEPTH cells
//   chained left (higher priority) to right (lower priority) form the array;
//   cell 0 is the head. On each broadcast command the cell reloads itself
//   from the new entry, its left neighbour or its right neighbour, which
//   keeps the array sorted (ties keep FIFO order).
//
//   Optional feature macro: PQ_AGE_EN (adds a saturating per-entry age).
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   push_i, pop_i, drop_i        broadcast commands (drop wins over push/pop)
//   push_prio_i, push_id_i       entry being pushed
//   drop_id_i                    id to remove
//   l_keep_i, l_hit_i            left neighbour keep / drop-hit chain
//   l_vld_i .. l_age_i           left neighbour entry
//   r_vld_i .. r_age_i, r_keep_i right neighbour entry and keep
//   keep_o                       this entry stays ahead of the pushed entry
//   hit_o                        drop hit at or left of this cell
//   vld_o, prio_o, id_o, age_o   registered entry
//   drop_vld_o                   one-cycle pulse: this cell held the dropped entry
module pq_shift_cell #(
    parameter int PW = 8,
    parameter int IW = 4,
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          drop_i,
    input  logic [PW-1:0] push_prio_i,
    input  logic [IW-1:0] push_id_i,
    input  logic [IW-1:0] drop_id_i,
    input  logic          l_keep_i,
    input  logic          l_hit_i,
    input  logic          l_vld_i,
    input  logic [PW-1:0] l_prio_i,
    input  logic [IW-1:0] l_id_i,
    input  logic [AW-1:0] l_age_i,
    input  logic          r_vld_i,
    input  logic [PW-1:0] r_prio_i,
    input  logic [IW-1:0] r_id_i,
    input  logic [AW-1:0] r_age_i,
    input  logic          r_keep_i,
    output logic          keep_o,
    output logic          hit_o,
    output logic          vld_o,
    output logic [PW-1:0] prio_o,
    output logic [IW-1:0] id_o,
    output logic [AW-1:0] age_o,
    output logic          drop_vld_o
);

    localparam logic [0:0] S_EMPTY    = 1'b0;
    localparam logic [0:0] S_OCCUPIED = 1'b1;

    localparam logic [1:0] SRC_HOLD  = 2'd0;
    localparam logic [1:0] SRC_LEFT  = 2'd1;
    localparam logic [1:0] SRC_RIGHT = 2'd2;
    localparam logic [1:0] SRC_NEW   = 2'd3;

    logic [0:0]    r_state;
    logic [PW-1:0] r_prio;
    logic [IW-1:0] r_id;
    logic          r_drop_vld;

    logic          w_match;
    logic          w_head;
    logic [1:0]    w_src;
    logic          w_nxt_vld;
    logic [PW-1:0] w_nxt_prio;
    logic [IW-1:0] w_nxt_id;

    assign vld_o      = (r_state == S_OCCUPIED);
    assign prio_o     = r_prio;
    assign id_o       = r_id;
    assign drop_vld_o = r_drop_vld;

    assign keep_o  = vld_o & (r_prio >= push_prio_i);
    assign w_match = vld_o & (r_id == drop_id_i);
    assign hit_o   = l_hit_i | w_match;

    // Only the head sees l_keep_i=1 with an empty left neighbour: in a sorted
    // array a cell with an empty left neighbour is itself empty, so its left
    // neighbour cannot keep.
    assign w_head = l_keep_i & ~l_vld_i;

    always_comb begin
        w_src = SRC_HOLD;
        if (drop_i) begin
            if (hit_o) w_src = SRC_RIGHT;
        end else if (push_i && pop_i) begin
            // Head leaves: entries that stay ahead of the new one move left,
            // the first cell whose right neighbour does not keep takes it.
            if (r_keep_i)              w_src = SRC_RIGHT;
            else if (keep_o || w_head) w_src = SRC_NEW;
        end else if (push_i) begin
            if (!l_keep_i)    w_src = SRC_LEFT;
            else if (!keep_o) w_src = SRC_NEW;
        end else if (pop_i) begin
            w_src = SRC_RIGHT;
        end
    end

    always_comb begin
        w_nxt_vld  = vld_o;
        w_nxt_prio = r_prio;
        w_nxt_id   = r_id;
        case (w_src)
            SRC_LEFT: begin
                w_nxt_vld  = l_vld_i;
                w_nxt_prio = l_prio_i;
                w_nxt_id   = l_id_i;
            end
            SRC_RIGHT: begin
                w_nxt_vld  = r_vld_i;
                w_nxt_prio = r_prio_i;
                w_nxt_id   = r_id_i;
            end
            SRC_NEW: begin
                w_nxt_vld  = 1'b1;
                w_nxt_prio = push_prio_i;
                w_nxt_id   = push_id_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_EMPTY;
            r_prio     <= '0;
            r_id       <= '0;
            r_drop_vld <= 1'b0;
        end else begin
            r_state    <= w_nxt_vld ? S_OCCUPIED : S_EMPTY;
            r_prio     <= w_nxt_prio;
            r_id       <= w_nxt_id;
            r_drop_vld <= drop_i & w_match & ~l_hit_i;
        end
    end

`ifdef PQ_AGE_EN
    logic [AW-1:0] r_age;
    logic [AW-1:0] w_nxt_age;

    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] a);
        return (&a) ? a : a + AW'(1);
    endfunction

    // Empty cells always carry age 0, whatever their source held.
    always_comb begin
        w_nxt_age = r_age;
        case (w_src)
            SRC_HOLD:  if (vld_o) w_nxt_age = sat_inc(r_age);
            SRC_LEFT:  w_nxt_age = l_vld_i ? sat_inc(l_age_i) : '0;
            SRC_RIGHT: w_nxt_age = r_vld_i ? sat_inc(r_age_i) : '0;
            default:   w_nxt_age = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_age <= '0;
        else       r_age <= w_nxt_age;
    end

    assign age_o = r_age;
`else
    logic w_unused_age;
    assign w_unused_age = ^{l_age_i, r_age_i};
    assign age_o        = '0;
`endif

endmodule
